// File: rtl/dc_pkg.sv
// Shared constants for the decoder mode sequencer: mux select codes,
// controller states and the one-hot LED helper.
package dc_pkg;

  localparam logic [1:0] MODE_DC1 = 2'd0;
  localparam logic [1:0] MODE_DC2 = 2'd1;
  localparam logic [1:0] MODE_F   = 2'd2;
  localparam logic [1:0] MODE_RAW = 2'd3;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_PAUSE  = 2'd2
  } dc_state_e;

  // Bit n set when m == n.
  function automatic logic [3:0] mode_onehot(input logic [1:0] m);
    return 4'b0001 << m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, consecutive-mismatch debounce
// counter and a one-cycle press pulse on each accepted 0->1 change.
// A button held through reset release is accepted silently; it has to be
// seen low once before a rising acceptance is allowed to pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic [1:0]    vld_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic          level_q, press_q;

  // Bring the raw button into clk; vld_q marks when sync2_q holds real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // Arm the press pulse once the button has genuinely been observed low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (vld_q[1] && !sync2_q) begin
      armed_q <= 1'b1;
    end
  end

  // Accept a new level after DEBOUNCE_CYC consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_TC) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= sync2_q & armed_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/dc_mode_ctrl.sv
// Decoder mux select sequencer: manual stepping with next/prev buttons, or
// automatic scan through all four modes with next acting as pause/resume.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_MANUAL | next/prev presses step mode +1/-1; auto_en=1 -> ST_AUTO
//   ST_AUTO   | mode steps every SCAN_CYC cycles; next press -> ST_PAUSE
//   ST_PAUSE  | mode and scan count frozen; next press -> ST_AUTO
//   (auto_en=0 in ST_AUTO/ST_PAUSE returns to ST_MANUAL ahead of anything else)
module dc_mode_ctrl
  import dc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCAN_CYC     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic [3:0] mode_led,
  output logic       paused
);

  localparam int SW = $clog2(SCAN_CYC);
  localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_CYC - 1);

  logic press_next, press_prev;
  logic next_level_unused, prev_level_unused;
  logic auto_s1_q, auto_s2_q;

  dc_state_e     state_q;
  logic [1:0]    mode_q;
  logic          chg_q;
  logic [3:0]    led_q;
  logic          paused_q;
  logic [SW-1:0] scan_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_next),
    .btn_level (next_level_unused),
    .btn_press (press_next)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_prev),
    .btn_level (prev_level_unused),
    .btn_press (press_prev)
  );

  // The slide switch is level-only, so it is synchronized but not debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
    end else begin
      auto_s1_q <= auto_en;
      auto_s2_q <= auto_s1_q;
    end
  end

  // Mode FSM with scan counter and all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_MANUAL;
      mode_q   <= MODE_DC1;
      chg_q    <= 1'b0;
      led_q    <= mode_onehot(MODE_DC1);
      paused_q <= 1'b0;
      scan_q   <= '0;
    end else begin
      chg_q <= 1'b0;
      unique case (state_q)
        ST_MANUAL: begin
          if (auto_s2_q) begin
            state_q <= ST_AUTO;
            scan_q  <= '0;
          end else if (press_next ^ press_prev) begin
            mode_q <= press_next ? mode_q + 2'd1 : mode_q - 2'd1;
            led_q  <= mode_onehot(press_next ? mode_q + 2'd1 : mode_q - 2'd1);
            chg_q  <= 1'b1;
          end
        end
        ST_AUTO: begin
          if (!auto_s2_q) begin
            state_q <= ST_MANUAL;
          end else if (press_next) begin
            state_q  <= ST_PAUSE;
            paused_q <= 1'b1;
          end else if (scan_q == SCAN_TC) begin
            mode_q <= mode_q + 2'd1;
            led_q  <= mode_onehot(mode_q + 2'd1);
            chg_q  <= 1'b1;
            scan_q <= '0;
          end else begin
            scan_q <= scan_q + SW'(1);
          end
        end
        ST_PAUSE: begin
          if (!auto_s2_q) begin
            state_q  <= ST_MANUAL;
            paused_q <= 1'b0;
          end else if (press_next) begin
            state_q  <= ST_AUTO;
            paused_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_MANUAL;
          paused_q <= 1'b0;
        end
      endcase
    end
  end

  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign mode_led = led_q;
  assign paused   = paused_q;

endmodule
